// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until both sources are
// ready, then issues the lowest-index ready entry to a single functional unit.
package rs_pkg;
  typedef struct packed {
    logic [6:0]  prd;
    logic [6:0]  pr1;
    logic [6:0]  pr2;
    logic        pr1_ready;
    logic        pr2_ready;
    logic [31:0] imm;
    logic [5:0]  rob_index;
    logic [6:0]  Opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
  } dispatch_pipeline_data;

  typedef struct packed {
    logic [6:0]  Opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [6:0]  pd;
    logic [6:0]  ps1;
    logic        ps1_ready;
    logic [6:0]  ps2;
    logic        ps2_ready;
    logic [5:0]  rob_index;
    logic [31:0] imm;
    logic [2:0]  fu;
  } rs_data;

  typedef struct packed {
    logic        valid;
    logic [6:0]  Opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [6:0]  pd;
    logic [6:0]  ps1;
    logic        ps1_ready;
    logic [6:0]  ps2;
    logic        ps2_ready;
    logic [5:0]  rob_index;
    logic [31:0] imm;
  } rs_entry_t;
endpackage

module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int FU_ID = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fu_rdy,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  dispatch_pipeline_data instr,
  output logic                  valid_out,
  output rs_data                data_out,
  output logic [6:0]            nr_reg,
  output logic                  nr_valid,
  input  logic [6:0]            reg1_rdy,
  input  logic                  reg1_rdy_valid,
  input  logic [6:0]            reg2_rdy,
  input  logic                  reg2_rdy_valid,
  input  logic [6:0]            reg3_rdy,
  input  logic                  reg3_rdy_valid,
  input  logic                  flush
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t ent_q [DEPTH];
  rs_entry_t ent_d [DEPTH];
  logic      valid_out_q, valid_out_d;
  rs_data    data_out_q, data_out_d;

  logic          has_free;
  logic [IW-1:0] free_idx;
  logic          any_elig;
  logic [IW-1:0] iss_idx;
  logic          accept;
  logic          issue;

  function automatic logic woken(input logic [6:0] p);
    return (reg1_rdy_valid && (reg1_rdy == p)) ||
           (reg2_rdy_valid && (reg2_rdy == p)) ||
           (reg3_rdy_valid && (reg3_rdy == p));
  endfunction

  // Descending scan leaves the lowest matching index in each encoder.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    any_elig = 1'b0;
    iss_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
      if (ent_q[i].valid && ent_q[i].ps1_ready && ent_q[i].ps2_ready) begin
        any_elig = 1'b1;
        iss_idx  = IW'(i);
      end
    end
  end

  assign ready_in = has_free && !flush;
  assign accept   = valid_in && ready_in;
  assign issue    = fu_rdy && any_elig && !flush;
  assign nr_valid = accept;
  assign nr_reg   = accept ? instr.prd : 7'd0;

  always_comb begin
    valid_out_d = 1'b0;
    data_out_d  = data_out_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        if (woken(ent_q[i].ps1)) ent_d[i].ps1_ready = 1'b1;
        if (woken(ent_q[i].ps2)) ent_d[i].ps2_ready = 1'b1;
      end
    end

    if (issue) begin
      ent_d[iss_idx].valid = 1'b0;
      valid_out_d = 1'b1;
      data_out_d  = '{Opcode:    ent_q[iss_idx].Opcode,
                      func3:     ent_q[iss_idx].func3,
                      func7:     ent_q[iss_idx].func7,
                      pd:        ent_q[iss_idx].pd,
                      ps1:       ent_q[iss_idx].ps1,
                      ps1_ready: 1'b1,
                      ps2:       ent_q[iss_idx].ps2,
                      ps2_ready: 1'b1,
                      rob_index: ent_q[iss_idx].rob_index,
                      imm:       ent_q[iss_idx].imm,
                      fu:        3'(FU_ID)};
    end

    // free_idx is never the issuing entry, so a slot freed this cycle waits a cycle.
    if (accept) begin
      ent_d[free_idx] = '{valid:     1'b1,
                          Opcode:    instr.Opcode,
                          func3:     instr.func3,
                          func7:     instr.func7,
                          pd:        instr.prd,
                          ps1:       instr.pr1,
                          ps1_ready: instr.pr1_ready || (instr.pr1 == 7'd0) || woken(instr.pr1),
                          ps2:       instr.pr2,
                          ps2_ready: instr.pr2_ready || (instr.pr2 == 7'd0) || woken(instr.pr2),
                          rob_index: instr.rob_index,
                          imm:       instr.imm};
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: vector table for the main flow plus
// hand sequences for flush, full-queue and asynchronous reset behaviour.
module tb_reservation_station;
  import rs_pkg::*;

  logic clk;
  logic reset;
  logic fu_rdy, valid_in, ready_in, valid_out, nr_valid, flush;
  dispatch_pipeline_data instr;
  rs_data data_out;
  logic [6:0] nr_reg;
  logic [6:0] reg1_rdy, reg2_rdy, reg3_rdy;
  logic reg1_rdy_valid, reg2_rdy_valid, reg3_rdy_valid;

  int checks = 0;
  int errors = 0;

  reservation_station #(.DEPTH(8), .FU_ID(5)) dut (
    .clk(clk), .reset(reset), .fu_rdy(fu_rdy), .valid_in(valid_in),
    .ready_in(ready_in), .instr(instr), .valid_out(valid_out),
    .data_out(data_out), .nr_reg(nr_reg), .nr_valid(nr_valid),
    .reg1_rdy(reg1_rdy), .reg1_rdy_valid(reg1_rdy_valid),
    .reg2_rdy(reg2_rdy), .reg2_rdy_valid(reg2_rdy_valid),
    .reg3_rdy(reg3_rdy), .reg3_rdy_valid(reg3_rdy_valid),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs, then expected comb outputs, expected registered outputs, and a
  // flag asking for data_out to be checked even when valid_out is low.
  typedef struct {
    int vin, prd, p1, p2, r1, r2, imm, fu, fl, w1, w2, w3;
    int e_rdy, e_nrv, e_nr, e_vo, e_pd, e_ps1, e_ps2, e_imm, cd;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    valid_in         = v.vin[0];
    instr            = '0;
    instr.prd        = 7'(v.prd);
    instr.pr1        = 7'(v.p1);
    instr.pr2        = 7'(v.p2);
    instr.pr1_ready  = v.r1[0];
    instr.pr2_ready  = v.r2[0];
    instr.imm        = 32'(v.imm);
    instr.rob_index  = 6'(v.prd);
    instr.Opcode     = 7'h33;
    instr.func3      = 3'd2;
    instr.func7      = 7'h20;
    fu_rdy           = v.fu[0];
    flush            = v.fl[0];
    reg1_rdy         = 7'(v.w1);
    reg1_rdy_valid   = (v.w1 != 0);
    reg2_rdy         = 7'(v.w2);
    reg2_rdy_valid   = (v.w2 != 0);
    reg3_rdy         = 7'(v.w3);
    reg3_rdy_valid   = (v.w3 != 0);
    #1;
    chk({tag, ".ready_in"}, 32'(ready_in), 32'(v.e_rdy));
    chk({tag, ".nr_valid"}, 32'(nr_valid), 32'(v.e_nrv));
    chk({tag, ".nr_reg"},   32'(nr_reg),   32'(v.e_nr));
    @(posedge clk);
    #1;
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(v.e_vo));
    if (v.e_vo != 0 || v.cd != 0) begin
      chk({tag, ".pd"},  32'(data_out.pd),  32'(v.e_pd));
      chk({tag, ".ps1"}, 32'(data_out.ps1), 32'(v.e_ps1));
      chk({tag, ".ps2"}, 32'(data_out.ps2), 32'(v.e_ps2));
      chk({tag, ".imm"}, data_out.imm,      32'(v.e_imm));
    end
    if (v.e_vo != 0) begin
      chk({tag, ".fu"},        32'(data_out.fu),        32'd5);
      chk({tag, ".ps_ready"},  32'({data_out.ps1_ready, data_out.ps2_ready}), 32'd3);
      chk({tag, ".rob_index"}, 32'(data_out.rob_index), 32'(v.e_pd % 64));
      chk({tag, ".opcode"},    32'({data_out.Opcode, data_out.func3, data_out.func7}),
          32'({7'h33, 3'd2, 7'h20}));
    end
  endtask

  initial begin
    //          vin prd p1 p2 r1 r2 imm  fu fl w1 w2 w3  rdy nrv nr vo  pd ps1 ps2 imm cd
    tbl[0]  = '{1, 10, 1, 2, 0, 0, 1,   0, 0, 0, 0, 0,  1, 1, 10, 0,  0, 0, 0, 0,  1};
    tbl[1]  = '{1, 11, 3, 4, 0, 0, 2,   0, 0, 0, 0, 0,  1, 1, 11, 0,  0, 0, 0, 0,  1};
    tbl[2]  = '{1, 12, 1, 3, 0, 0, 3,   0, 0, 0, 0, 0,  1, 1, 12, 0,  0, 0, 0, 0,  1};
    tbl[3]  = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 1, 0, 0,  1, 0, 0,  0,  0, 0, 0, 0,  1};
    tbl[4]  = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 2, 0,  1, 0, 0,  0,  0, 0, 0, 0,  1};
    tbl[5]  = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 0, 0,  1,  10, 1, 2, 1, 1};
    tbl[6]  = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 0, 0,  0,  10, 1, 2, 1, 1};
    tbl[7]  = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 3,  1, 0, 0,  0,  10, 1, 2, 1, 1};
    tbl[8]  = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 0, 0,  1,  12, 1, 3, 3, 1};
    tbl[9]  = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 0, 0,  0,  12, 1, 3, 3, 1};
    tbl[10] = '{1, 20, 5, 6, 0, 1, 32,  0, 0, 5, 0, 0,  1, 1, 20, 0,  12, 1, 3, 3, 1};
    tbl[11] = '{0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 0,  0,  12, 1, 3, 3, 1};
    tbl[12] = '{0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 0,  0,  12, 1, 3, 3, 1};
    tbl[13] = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 0, 0,  1,  20, 5, 6, 32, 1};
    tbl[14] = '{1, 21, 0, 7, 0, 1, 33,  1, 0, 0, 0, 0,  1, 1, 21, 0,  20, 5, 6, 32, 1};
    tbl[15] = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 0, 0,  1,  21, 0, 7, 33, 1};
    tbl[16] = '{1, 22, 0, 0, 0, 0, 34,  1, 0, 0, 0, 0,  1, 1, 22, 0,  21, 0, 7, 33, 1};
    tbl[17] = '{1, 23, 8, 9, 0, 0, 35,  1, 0, 0, 0, 0,  1, 1, 23, 1,  22, 0, 0, 34, 1};
    tbl[18] = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 8, 8, 9,  1, 0, 0,  0,  22, 0, 0, 34, 1};
    tbl[19] = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 0, 0,  1,  23, 8, 9, 35, 1};
    tbl[20] = '{0, 0,  0, 0, 0, 0, 0,   1, 0, 50, 0, 0, 1, 0, 0,  0,  23, 8, 9, 35, 1};

    reset = 1'b0;
    valid_in = 1'b0; fu_rdy = 1'b0; flush = 1'b0; instr = '0;
    reg1_rdy = '0; reg2_rdy = '0; reg3_rdy = '0;
    reg1_rdy_valid = 1'b0; reg2_rdy_valid = 1'b0; reg3_rdy_valid = 1'b0;
    #3;
    chk("rst.valid_out", 32'(valid_out), 32'd0);
    chk("rst.data_zero", 32'(data_out == '0), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 3; i++)
      step('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1}, "idle");

    for (int i = 0; i < 21; i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // Flush beats both accept and issue of a ready entry; pd11 is also dropped.
    step('{1, 30, 0, 0, 0, 0, 48, 0, 0, 0, 0, 0, 1, 1, 30, 0, 0, 0, 0, 0, 0}, "fl_enq");
    step('{1, 31, 0, 0, 0, 0, 49, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "flush");
    step('{0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}, "fl_b4a");
    step('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}, "fl_b4b");
    step('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}, "fl_idle");

    // Fill all entries, try one extra, then drain in index order.
    for (int i = 0; i < 8; i++)
      step('{1, 40 + i, 60, 61, 0, 0, 64 + i, 1, 0, 0, 0, 0, 1, 1, 40 + i, 0, 0, 0, 0, 0, 0},
           $sformatf("fill%0d", i));
    step('{1, 99, 60, 61, 0, 0, 99, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "full_extra");
    step('{0, 0, 0, 0, 0, 0, 0, 1, 0, 60, 61, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "full_bcast");
    for (int k = 0; k < 8; k++)
      step('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, (k == 0) ? 0 : 1, 0, 0, 1, 40 + k, 60, 61,
             64 + k, 0}, $sformatf("drain%0d", k));
    step('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 47, 60, 61, 71, 1}, "drain_end");

    // Asynchronous reset mid-cycle clears the held data_out immediately.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst.valid_out", 32'(valid_out), 32'd0);
    chk("arst.data_zero", 32'(data_out == '0), 32'd1);
    chk("arst.ready_in", 32'(ready_in), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries.
REQ-002 SHALL have parameter FU_ID, default 0, value driven on data_out.fu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fu_rdy  input  1  downstream FU can accept an instruction this cycle.
REQ-006 SHALL have port valid_in  input  1  dispatch offers instr.
REQ-007 SHALL have port ready_in  output  1  RS can accept.
REQ-008 SHALL have port instr  input  dispatch_pipeline_data  fields used: prd[6:0], pr1[6:0], pr2[6:0], pr1_ready, pr2_ready, imm[31:0], rob_index, Opcode[6:0], func3, func7.
REQ-009 SHALL have port valid_out  output  1  data_out valid this cycle.
REQ-010 SHALL have port data_out  output  rs_data  fields: Opcode, func3, func7, pd, ps1, ps1_ready, ps2, ps2_ready, rob_index, imm, fu.
REQ-011 SHALL have ports nr_reg  output  7, and nr_valid  output  1  physical destination to mark not-ready.
REQ-012 SHALL have ports regN_rdy  input  7, and regN_rdy_valid  input  1 (N=1..3)  wakeup broadcasts.
REQ-013 SHALL have port flush  input  1  synchronous clear of all entries.

Function
REQ-014 Entry SHALL hold: valid, Opcode, func3, func7, pd, ps1, ps1_ready, ps2, ps2_ready, rob_index, imm.
REQ-015 ready_in SHALL be combinational: 1 iff at least one entry is invalid and flush=0.
REQ-016 Accept SHALL occur when valid_in && ready_in; instr is written into the lowest-index invalid entry at the clock edge.
REQ-017 On accept, nr_valid SHALL be 1 and nr_reg = instr.prd in the same cycle (combinational); otherwise nr_valid=0 and nr_reg=0.
REQ-018 Source readiness on write SHALL be instr.prN_ready OR (prN==0) OR (any regK_rdy_valid with regK_rdy==prN in the same cycle).
REQ-019 Each cycle, every valid entry SHALL set psN_ready when any of the three broadcasts matches psN; ready bits never clear except by entry free.
REQ-020 An entry SHALL be issue-eligible when valid, ps1_ready and ps2_ready are set, using the registered ready bits only (a broadcast makes an entry eligible in the following cycle).
REQ-021 If fu_rdy=1 and any entry is eligible, the lowest-index eligible entry SHALL be freed at the edge, its contents registered into data_out (fu=FU_ID, ps1_ready=ps2_ready=1), and valid_out=1 for exactly that following cycle.
REQ-022 If fu_rdy=0 or no entry is eligible, valid_out SHALL be 0 next cycle and data_out SHALL hold its previous value.
REQ-023 At most one issue and one accept SHALL occur per cycle; an entry freed by issue is not reusable until the next cycle.
REQ-024 Full (all DEPTH valid): ready_in=0, valid_in ignored, no nr_valid.
REQ-025 flush=1 SHALL invalidate all entries and force valid_out=0 at the edge; flush beats accept and issue in the same cycle.
REQ-026 Broadcasts for registers not present SHALL have no effect; duplicate broadcasts on several channels SHALL be harmless.

Reset
REQ-027 While reset=0 (asynchronous): all entries invalid, valid_out=0, data_out all zero; ready_in=1 after release.

Verification
REQ-028 Reset then idle 3 cycles -> valid_out=0, ready_in=1, nr_valid=0.
REQ-029 Enqueue (prd10,pr1=1,pr2=2), (prd11,3,4), (prd12,1,3), all not-ready -> nr_valid pulses with nr_reg 10, 11, 12; no issue.
REQ-030 Broadcast reg1 then reg2 -> exactly one issue, pd=10 ps1=1 ps2=2 imm=00000001; broadcast reg3 -> one issue pd=12 imm=00000003; pd=11 never issues (waits on 4).
REQ-031 Enqueue DEPTH not-ready instructions -> ready_in=0 afterwards; extra valid_in ignored, nr_valid=0.
REQ-032 Enqueue while reg1_rdy=pr1 broadcast same cycle with pr2_ready=1 -> issues next cycle with fu_rdy=1; with fu_rdy=0 held, no issue until fu_rdy=1.
REQ-033 Flush with pd=11 pending -> all entries cleared, valid_out=0, later broadcast of reg4 produces no issue.
